ipg_rx: RTL

//  Receive-side counterpart of the IPG transmit path. Sits between the 66b block

---
 rtl/ipg_rx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ipg_rx.sv
// IPG receive filter: pulls IPG request/reply blocks out of the 66b RX stream
// into two message FIFOs and replaces each one with an idle block toward the MAC.
module ipg_rx_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          rd_ok;
    logic          wr_ok;

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_ok = rd_en && valid;
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign wr_ok = wr_en && (!full || rd_ok);
    assign drop  = wr_en && !wr_ok;
    assign head  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end
endmodule

module ipg_rx #(
    parameter logic [7:0] REQ_TYPE   = 8'hA5,
    parameter logic [7:0] REPLY_TYPE = 8'h5A,
    parameter int         FIFO_DEPTH = 32,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       encoded_rx_hdr,
    input  logic [63:0]      encoded_rx_data,
    input  logic             encoded_rx_valid,
    output logic [1:0]       proced_encoded_rx_hdr,
    output logic [63:0]      proced_encoded_rx_data,
    output logic             proced_encoded_rx_valid,
    output logic [63:0]      ipg_req_chunk,
    output logic             ipg_req_valid,
    input  logic             ipg_req_ready,
    output logic [63:0]      ipg_reply_chunk,
    output logic             ipg_reply_valid,
    input  logic             ipg_reply_ready,
    output logic [CNT_W-1:0] req_drop_cnt,
    output logic [CNT_W-1:0] reply_drop_cnt,
    output logic [CNT_W-1:0] proto_err_cnt
);
    typedef enum logic {S_IDLE, S_FRAME} state_t;

    state_t      state;
    logic [7:0]  blk_type;
    logic        is_ctrl, is_data, is_bad, is_start, is_term, is_ipg_type;
    logic        take_req, take_reply, proto_err;
    logic        req_wr, reply_wr;
    logic [63:0] pend_data;
    logic        req_drop, reply_drop;

    always_comb begin
        blk_type    = encoded_rx_data[7:0];
        is_ctrl     = (encoded_rx_hdr == 2'b01);
        is_data     = (encoded_rx_hdr == 2'b10);
        is_bad      = !is_ctrl && !is_data;
        is_start    = is_ctrl && (blk_type == 8'h78);
        is_term     = is_ctrl && (blk_type inside {8'h87, 8'h99, 8'hAA, 8'hB4,
                                                   8'hCC, 8'hD2, 8'hE1, 8'hFF});
        is_ipg_type = is_ctrl && ((blk_type == REQ_TYPE) || (blk_type == REPLY_TYPE));
        take_req    = encoded_rx_valid && (state == S_IDLE) && !is_start &&
                      is_ctrl && (blk_type == REQ_TYPE);
        take_reply  = encoded_rx_valid && (state == S_IDLE) && !is_start &&
                      is_ctrl && (blk_type == REPLY_TYPE);
        proto_err   = encoded_rx_valid && (is_bad ||
                      ((state == S_IDLE) && is_data) ||
                      ((state == S_FRAME) && is_ipg_type));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else if (encoded_rx_valid) begin
            if (is_bad) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE:  if (is_start) state <= S_FRAME;
                    S_FRAME: if (is_term)  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Net path register; extracted IPG blocks become idle blocks to the MAC.
    always_ff @(posedge clk) begin
        if (reset) begin
            proced_encoded_rx_hdr   <= 2'b01;
            proced_encoded_rx_data  <= 64'h1e;
            proced_encoded_rx_valid <= 1'b0;
        end else begin
            proced_encoded_rx_valid <= encoded_rx_valid;
            if (take_req || take_reply) begin
                proced_encoded_rx_hdr  <= 2'b01;
                proced_encoded_rx_data <= 64'h1e;
            end else if (encoded_rx_valid) begin
                proced_encoded_rx_hdr  <= encoded_rx_hdr;
                proced_encoded_rx_data <= encoded_rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_wr    <= 1'b0;
            reply_wr  <= 1'b0;
            pend_data <= '0;
        end else begin
            req_wr   <= take_req;
            reply_wr <= take_reply;
            if (take_req || take_reply) begin
                pend_data <= encoded_rx_data;
            end
        end
    end

    ipg_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (req_wr),
        .wr_data (pend_data),
        .rd_en   (ipg_req_ready),
        .head    (ipg_req_chunk),
        .valid   (ipg_req_valid),
        .drop    (req_drop)
    );

    ipg_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_reply_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (reply_wr),
        .wr_data (pend_data),
        .rd_en   (ipg_reply_ready),
        .head    (ipg_reply_chunk),
        .valid   (ipg_reply_valid),
        .drop    (reply_drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            req_drop_cnt   <= '0;
            reply_drop_cnt <= '0;
            proto_err_cnt  <= '0;
        end else begin
            if (req_drop && (req_drop_cnt != '1)) begin
                req_drop_cnt <= req_drop_cnt + CNT_W'(1);
            end
            if (reply_drop && (reply_drop_cnt != '1)) begin
                reply_drop_cnt <= reply_drop_cnt + CNT_W'(1);
            end
            if (proto_err && (proto_err_cnt != '1)) begin
                proto_err_cnt <= proto_err_cnt + CNT_W'(1);
            end
        end
    end
endmodule
